wb_select_stage: RTL
====================

# wb_select_stage

Parametrised writeback stage. Selects one of NSRC result sources per instruction using a priority rule, with source 0 as the default. For the call source it redirects the destination to the return-address register. The selected result is held in a 2-entry skid buffer with valid/ready flow control and drives the register-file write port. The stage also provides operand-forwarding matches and a retire counter, and sits between the memory-access stage and the register file.

## Interface
Parameters:
- DATA_W, 32, result and register data width
- NSRC, 3, number of result sources (index 0 = ALU default, 1 = load, 2 = PC/call)
- ADDR_W, 4, register-address width
- CALL_SRC, 2, source index whose selection forces destination to RA_IDX
- RA_IDX, 15, return-address register index

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- flush  in  1  drop all buffered entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry
- src_data  in  NSRC*DATA_W  source results; source i at bits [i*DATA_W +: DATA_W]
- src_sel  in  NSRC  per-source select flags
- in_rd  in  ADDR_W  destination register
- in_wb  in  1  instruction writes a register
- out_ready  in  1  register-file port accepts the write
- out_valid  out  1  head entry valid
- rf_we  out  1  register-file write enable
- rf_waddr  out  ADDR_W  register-file write address
- rf_wdata  out  DATA_W  register-file write data
- rs1_addr, rs2_addr  in  ADDR_W each  decode-stage operand addresses
- fwd1_hit, fwd2_hit  out  1 each  operand matches a buffered write
- fwd1_data, fwd2_data  out  DATA_W each  forwarded value
- retire_cnt  out  32  count of completed writeback handshakes

## Operation
**Selection** (combinational, at input):
- The highest-index set bit of src_sel wins.
- If src_sel is 0, source 0 is selected.
- If the selected index is CALL_SRC, the entry's rd becomes RA_IDX and in_rd is ignored.

**Buffer:** two entries, HEAD (output) and SKID. Each entry holds {valid, wb, rd, data}.
- State EMPTY (no valid entries), ONE (HEAD valid), TWO (both valid).
- in_ready = !SKID.valid.
- Input accept = in_valid & in_ready. Output handshake = out_valid & out_ready.
- EMPTY: accept → write HEAD, go to ONE.
- ONE:
  - accept and handshake → write HEAD, stay in ONE.
  - accept only → write SKID, go to TWO.
  - handshake only → go to EMPTY.
- TWO:
  - handshake → SKID moves to HEAD, go to ONE.
  - No accept is possible in TWO.
- Order is preserved: HEAD is always older than SKID.

**Outputs:**
- out_valid = HEAD.valid.
- rf_waddr and rf_wdata come from HEAD.
- rf_we = HEAD.valid & HEAD.wb & out_ready.
- An entry with wb=0 still completes a handshake and still counts as retired.

**Forwarding:**
- fwdN_hit when a valid entry with wb=1 has rd == rsN_addr.
- If both entries match, SKID (the younger entry) supplies fwdN_data.
- fwdN_data is 0 when there is no hit.

**retire_cnt:** increments by 1 per output handshake and wraps from 2^32-1 to 0. It is not cleared by flush.

**flush:**
- Next state is EMPTY. Any same-cycle accept is discarded.
- A handshake in the same cycle still completes: the rf write occurs and the counter increments.

## Timing
- Reset:
  - The stage enters EMPTY.
  - out_valid=0, rf_we=0, rf_waddr=0, rf_wdata=0, fwd*_hit=0, fwd*_data=0, retire_cnt=0.
  - in_ready=1 from the first cycle after reset deasserts.
- rst takes priority over flush, and flush over accept/handshake.
- Latency: an entry accepted in cycle t is presented on out_valid in cycle t+1.
  - With out_ready held at 1, throughput is 1 entry/cycle in steady state.
- in_ready depends only on registered state, with no combinational path from out_ready.
  - After a one-cycle stall in ONE, in_ready falls in the next cycle and recovers one cycle after the draining handshake.
- Forwarding outputs are combinational from registered state and the rs*_addr inputs.
- rst asserted mid-stream discards both entries; no rf_we occurs in that cycle or the next.

## Test plan
- src_sel=3'b000, src_data={P,L,A}={0x100,0xBEEF,0x1234}, in_rd=5, in_wb=1, out_ready=1 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, retire_cnt=1.
- src_sel=3'b110 (call and load both set), in_rd=3 → rf_waddr=15, rf_wdata=0x100. src_sel=3'b010 → rf_wdata=0xBEEF, rf_waddr=3.
- out_ready=0 while sending entries E1 and E2 → state TWO, in_ready=0, E3 held upstream. Raise out_ready → E1, E2, E3 are written in order on consecutive handshakes, with no loss or duplication.
- TWO state, HEAD {rd=7, data=0xA}, SKID {rd=7, data=0xB}, rs1_addr=7 → fwd1_hit=1, fwd1_data=0xB. With rs2_addr=8 → fwd2_hit=0, fwd2_data=0. An entry with wb=0 and rd=7 alone → fwd1_hit=0.
- flush in TWO with out_ready=1 and in_valid=1 → HEAD written once and retire_cnt+1; SKID and the new input dropped; next cycle out_valid=0, in_ready=1.
- Preload retire_cnt to 0xFFFFFFFF via 2^32-1 handshakes (or a forced value), then one more handshake → retire_cnt=0. rst mid-stream → all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/wb_select_stage.sv
// Writeback stage: picks one result source per instruction and buffers it in a
// two-entry skid buffer that drives the register-file write port.
module wb_select_stage #(
  parameter int DATA_W   = 32,
  parameter int NSRC     = 3,
  parameter int ADDR_W   = 4,
  parameter int CALL_SRC = 2,
  parameter int RA_IDX   = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NSRC*DATA_W-1:0] src_data,
  input  logic [NSRC-1:0]        src_sel,
  input  logic [ADDR_W-1:0]      in_rd,
  input  logic                   in_wb,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  input  logic [ADDR_W-1:0]      rs1_addr,
  input  logic [ADDR_W-1:0]      rs2_addr,
  output logic                   fwd1_hit,
  output logic                   fwd2_hit,
  output logic [DATA_W-1:0]      fwd1_data,
  output logic [DATA_W-1:0]      fwd2_data,
  output logic [31:0]            retire_cnt
);

  localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} bufState_t;

  typedef struct packed {
    logic              wb;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  bufState_t         state;
  entry_t            head;
  entry_t            skid;
  entry_t            newEntry;
  logic [SEL_W-1:0]  selIdx;
  logic [31:0]       retireCnt;
  logic              headValid;
  logic              skidValid;
  logic              accept;
  logic              handshake;

  // Highest set select bit wins; an all-zero select falls back to the ALU source.
  always_comb begin
    selIdx = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_sel[i]) selIdx = SEL_W'(i);
    end
    newEntry.wb   = in_wb;
    newEntry.data = src_data[selIdx*DATA_W +: DATA_W];
    newEntry.rd   = (selIdx == SEL_W'(CALL_SRC)) ? ADDR_W'(RA_IDX) : in_rd;
  end

  assign headValid = (state != EMPTY);
  assign skidValid = (state == TWO);
  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;

  assign in_ready   = !skidValid;
  assign out_valid  = headValid;
  assign rf_we      = headValid & head.wb & out_ready & !rst;
  assign rf_waddr   = head.rd;
  assign rf_wdata   = head.data;
  assign retire_cnt = retireCnt;

  // The retire counter keeps running across flushes; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      head      <= '0;
      skid      <= '0;
      retireCnt <= '0;
    end else begin
      if (handshake) retireCnt <= retireCnt + 32'd1;
      if (flush) begin
        state <= EMPTY;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              head  <= newEntry;
              state <= ONE;
            end
          end
          ONE: begin
            if (accept && handshake) begin
              head <= newEntry;
            end else if (accept) begin
              skid  <= newEntry;
              state <= TWO;
            end else if (handshake) begin
              state <= EMPTY;
            end
          end
          TWO: begin
            if (handshake) begin
              head  <= skid;
              state <= ONE;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

  // The younger skid entry overrides the head when both match an operand.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    if (headValid && head.wb && head.rd == rs1_addr) begin
      fwd1_hit  = 1'b1;
      fwd1_data = head.data;
    end
    if (skidValid && skid.wb && skid.rd == rs1_addr) begin
      fwd1_hit  = 1'b1;
      fwd1_data = skid.data;
    end
    if (headValid && head.wb && head.rd == rs2_addr) begin
      fwd2_hit  = 1'b1;
      fwd2_data = head.data;
    end
    if (skidValid && skid.wb && skid.rd == rs2_addr) begin
      fwd2_hit  = 1'b1;
      fwd2_data = skid.data;
    end
  end

endmodule
